// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Bit timing comes from a free cycle counter on clk.
module uart_tx #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);

    localparam int CPB   = (CLK_FRE * 1000000) / BAUD_RATE;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx: clock cycles per bit must be at least 2");
    end
    if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             pin_q, pin_d;
    logic             rdy_q, rdy_d;
    logic             bit_done;
    logic [2:0]       nxt_bit;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the shift register is reset too, it is plain flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pin_q   <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pin_q   <= pin_d;
            rdy_q   <= rdy_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        par_d    = par_q;
        pin_d    = pin_q;
        rdy_d    = rdy_q;
        bit_done = (cnt_q == CNT_LAST);
        nxt_bit  = bit_q + 3'd1;

        if (state_q != S_IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                pin_d = 1'b1;
                rdy_d = 1'b1;
                if (tx_data_valid && rdy_q) begin
                    shift_d = tx_data;
                    par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    cnt_d   = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    pin_d   = 1'b0;
                    rdy_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    pin_d   = shift_q[0];
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY != 0) begin
                            pin_d   = par_q;
                            state_d = S_PAR;
                        end else begin
                            pin_d   = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d = nxt_bit;
                        pin_d = shift_q[nxt_bit];
                    end
                end
            end
            S_PAR: begin
                if (bit_done) begin
                    pin_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    // Ready re-asserts on the edge that ends the last stop bit.
                    if (stop_q == STOP_LAST) begin
                        pin_d   = 1'b1;
                        rdy_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                pin_d   = 1'b1;
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_pin        = pin_q;
    assign tx_data_ready = rdy_q;

endmodule
